rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel.
- Successor to the combinational fixed-width muxes. It adds a runtime-selectable arbitration mode (round-robin, fixed priority, forced select), backpressure and one-cycle registered latency.
- Sits between multiple requesters (e.g. writeback/bypass sources, bus masters) and a single downstream consumer in the core pipeline.

Parameters:
- WIDTH, 32, data bits per channel.
- NUM, 4, number of input channels, legal range 2..64, need not be a power of two.
- SEL_W, $clog2(NUM), width of channel index fields; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NUM*WIDTH  flattened channel data; channel i is din[i*WIDTH +: WIDTH].
- din_valid  input  NUM  per-channel request.
- din_ready  output  NUM  per-channel accept; at most one bit set.
- mode  input  2  arbitration mode: 0 round-robin, 1 fixed priority (lowest index wins), 2 forced select, 3 reserved and treated as 1.
- force_sel  input  SEL_W  channel index used in mode 2.
- dout  output  WIDTH  registered selected data.
- dout_valid  output  1  dout holds a valid beat.
- dout_ready  input  1  consumer accept.
- dout_sel  output  SEL_W  index of the channel that produced dout.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_valid=0, dout_sel=0, round-robin pointer ptr=0. din_ready is 0 combinationally while rst_n=0.
- out_free = !dout_valid || dout_ready.
- Grant is combinational each cycle and one-hot or zero:
  - Mode 0: first i with din_valid[i]=1, searching ptr, ptr+1, ... NUM-1, 0, ... ptr-1.
  - Mode 1/3: lowest i with din_valid[i]=1.
  - Mode 2: grant force_sel only if force_sel<NUM and din_valid[force_sel]=1. Otherwise no grant; other channels are never granted.
- din_ready[i] = out_free && grant[i]. din_ready never depends on din_valid of the granted channel beyond the grant itself.
- Transfer on channel i (din_valid[i] && din_ready[i]), at the next edge:
  - dout <= din slice i, dout_sel <= i, dout_valid <= 1.
  - ptr <= (i==NUM-1) ? 0 : i+1.
  - ptr updates on transfers in every mode.
- out_free with no grant: dout_valid <= 0; dout and dout_sel keep their last values.
- dout_valid=1 and dout_ready=0: dout, dout_sel and dout_valid hold stable; all din_ready are 0.
- Latency is 1 cycle from input transfer to dout_valid. Throughput is 1 beat/cycle when dout_ready is held high: simultaneous output consume and input accept in the same cycle is required.
- mode and force_sel are sampled every cycle. A change takes effect on the same cycle's grant, with no drain required. ptr is not reset by mode changes.
- Requesters may drop din_valid without a transfer; the arbiter holds no state for un-granted requests.
- Reset asserted mid-beat discards the held beat immediately (dout_valid=0 asynchronously).
- No X on outputs after reset regardless of din contents.

Test Plan:
- Reset: hold rst_n=0 with all din_valid=1 -> din_ready=0, dout_valid=0, dout=0, dout_sel=0. Release with NUM=4, mode 0, dout_ready=1 -> first transfer is channel 0, dout_valid=1 one cycle later.
- Round-robin fairness:
  - NUM=4, mode 0, all valid, dout_ready=1, din[i]=32'hA0+i -> dout sequence A0,A1,A2,A3,A0 with dout_sel 0,1,2,3,0 on consecutive cycles.
  - Then drop valid on channel 1 -> sequence skips 1.
- Backpressure: mode 0, dout_ready=0 for 3 cycles after the first beat -> dout stable at the first beat, din_ready all 0. dout_ready=1 -> next beat follows in the same cycle it is consumed, with no bubble.
- Fixed priority and reserved mode: mode 1 with valid=4'b1010 -> channel 1 wins every cycle. Mode 3 behaves identically. Switching to mode 0 then grants ptr-ordered channel 3.
- Forced select:
  - mode 2, force_sel=2, valid=4'b1111 -> only channel 2 is ever granted.
  - force_sel=2 with valid[2]=0 -> no transfer; dout_valid falls after consume.
  - NUM=3, force_sel=3 (out of range) -> no grant.
- Non-power-of-two wrap and reset mid-operation:
  - NUM=3, mode 0, all valid -> dout_sel 0,1,2,0.
  - Assert rst_n=0 while dout_valid=1 and dout_ready=0 -> dout_valid=0 immediately. After release ptr=0 and channel 0 is granted first.

Source files
------------

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux
// Description : N-channel arbitrating multiplexer with valid/ready handshakes,
//               runtime-selectable arbitration (round-robin, fixed priority,
//               forced select) and a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int NUM   = 4,
    localparam int SEL_W = $clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM*WIDTH-1:0] din,
    input  logic [NUM-1:0]       din_valid,
    output logic [NUM-1:0]       din_ready,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     force_sel,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [SEL_W-1:0]     dout_sel
);

    localparam logic [1:0]       C_MODE_RR     = 2'd0;
    localparam logic [1:0]       C_MODE_FORCE  = 2'd2;
    localparam logic [SEL_W-1:0] C_LAST_CH     = SEL_W'(NUM - 1);

    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [SEL_W-1:0] r_dout_sel;
    logic [SEL_W-1:0] r_ptr;

    logic             w_out_free;
    logic             w_gnt_any;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_xfer;

    // The output register can take a new beat when empty or being drained now.
    assign w_out_free = !r_dout_valid || dout_ready;
    assign w_xfer     = w_out_free && w_gnt_any;

    // Pick the winning channel for this cycle according to the selected mode.
    always_comb begin : p_grant
        int               c;
        logic [SEL_W-1:0] v_idx;
        c         = 0;
        v_idx     = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        case (mode)
            C_MODE_RR: begin
                // Search starts at the pointer and wraps at NUM, which need
                // not be a power of two.
                for (int k = 0; k < NUM; k++) begin
                    c = int'(r_ptr) + k;
                    if (c >= NUM) begin
                        c = c - NUM;
                    end
                    v_idx = SEL_W'(c);
                    if (!w_gnt_any && din_valid[v_idx]) begin
                        w_gnt_any = 1'b1;
                        w_gnt_idx = v_idx;
                    end
                end
            end
            C_MODE_FORCE: begin
                // Out-of-range indices never grant; no fallback to others.
                if ((int'(force_sel) < NUM) && din_valid[force_sel]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = force_sel;
                end
            end
            default: begin
                // Fixed priority, also used for the reserved mode encoding.
                for (int k = 0; k < NUM; k++) begin
                    v_idx = SEL_W'(k);
                    if (!w_gnt_any && din_valid[v_idx]) begin
                        w_gnt_any = 1'b1;
                        w_gnt_idx = v_idx;
                    end
                end
            end
        endcase
    end

    // Accept is one-hot on the granted channel and forced low during reset.
    always_comb begin : p_ready
        din_ready = '0;
        if (rst_n && w_xfer) begin
            din_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Output stage and round-robin pointer; the pointer advances on every
    // transfer regardless of mode so switching back to round-robin is fair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_sel   <= '0;
            r_ptr        <= '0;
        end else if (w_out_free) begin
            if (w_gnt_any) begin
                r_dout       <= din[int'(w_gnt_idx)*WIDTH +: WIDTH];
                r_dout_sel   <= w_gnt_idx;
                r_dout_valid <= 1'b1;
                r_ptr        <= (w_gnt_idx == C_LAST_CH) ? '0
                                                         : w_gnt_idx + SEL_W'(1);
            end else begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_sel   = r_dout_sel;

endmodule
`default_nettype wire
